// File: rtl/fc_layer_sequencer_pkg.sv
// Shared definitions for the FC layer sequencer: state codes, width defaults
// and the cycle-counter width.
package fc_seq_pkg;

  localparam int ADDR_W_DEF = 27;
  localparam int DIM_W_DEF  = 12;
  localparam int CYC_W      = 32;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LIF_GO = 4'd1;
  localparam logic [3:0] S_LIF_WT = 4'd2;
  localparam logic [3:0] S_LW_GO  = 4'd3;
  localparam logic [3:0] S_LW_WT  = 4'd4;
  localparam logic [3:0] S_FC_GO  = 4'd5;
  localparam logic [3:0] S_FC_WT  = 4'd6;
  localparam logic [3:0] S_SOF_GO = 4'd7;
  localparam logic [3:0] S_SOF_WT = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;
  localparam logic [3:0] S_ERR    = 4'd10;

  function automatic logic is_go(input logic [3:0] s);
    return (s == S_LIF_GO) || (s == S_LW_GO) || (s == S_FC_GO) || (s == S_SOF_GO);
  endfunction

  function automatic logic is_wait(input logic [3:0] s);
    return (s == S_LIF_WT) || (s == S_LW_WT) || (s == S_FC_WT) || (s == S_SOF_WT);
  endfunction

endpackage

// File: rtl/fc_layer_sequencer_wdog.sv
// Per-phase watchdog: down-counter reloaded on each GO cycle, expires after
// TIMEOUT cycles measured from that GO cycle.
module fc_seq_wdog
  import fc_seq_pkg::*;
#(
  parameter int TIMEOUT = 1048576
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] cnt;

  // The GO cycle is the first counted cycle, so reload with TIMEOUT-2 and
  // flag the last wait cycle when the count has run out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CNT_W'(TIMEOUT - 2);
    end else if (run && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = run && (cnt == '0);

endmodule

// File: rtl/fc_layer_sequencer.sv
// FC layer sequencer: walks load-input, load-weights, compute, store-output
// for one layer per start. Optional watchdog built with FC_SEQ_WDOG_EN.
//
// state    | meaning
// IDLE     | waiting for start, config latched on accept
// LIF_GO   | pulse lif_start, ld_base_addr = in_addr
// LIF_WT   | wait ld_done for input fetch
// LW_GO    | pulse lw_start, ld_base_addr = w_addr
// LW_WT    | wait ld_done for weight(+bias) fetch
// FC_GO    | pulse fc_start
// FC_WT    | wait fc_done
// SOF_GO   | pulse sof_start, ld_base_addr = out_addr
// SOF_WT   | wait ld_done for output store
// DONE     | one-cycle done pulse
// ERR      | watchdog tripped, held until rst
module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DIM_W   = DIM_W_DEF,
  parameter int TIMEOUT = 1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cin,
  input  logic [DIM_W-1:0]  cout,
  input  logic              has_bias,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [ADDR_W-1:0] out_addr,
  output logic              lif_start,
  output logic              lw_start,
  output logic              sof_start,
  output logic [ADDR_W-1:0] ld_base_addr,
  output logic [DIM_W-1:0]  ld_cin,
  output logic [DIM_W-1:0]  ld_cout,
  output logic              ld_has_bias,
  input  logic              ld_done,
  output logic              fc_start,
  input  logic              fc_done,
  output logic              busy,
  output logic              done,
  output logic [CYC_W-1:0]  cycles,
  output logic              error
);

  logic [3:0]        state, state_n;
  logic              hold_off;
  logic              accept;
  logic              wd_expire;
  logic [ADDR_W-1:0] w_addr_q, out_addr_q;

`ifdef FC_SEQ_WDOG_EN
  fc_seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (is_go(state)),
    .run    (is_wait(state)),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) error <= 1'b0;
    else     error <= error | (state_n == S_ERR);
  end
`else
  assign wd_expire = 1'b0;
  assign error     = 1'b0;
`endif

  // hold_off blocks the first IDLE cycle after DONE so a held start re-arms late.
  assign accept = (state == S_IDLE) && start && !hold_off;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (accept) state_n = (cin == '0 || cout == '0) ? S_DONE : S_LIF_GO;
      S_LIF_GO: state_n = S_LIF_WT;
      S_LIF_WT: if (ld_done) state_n = S_LW_GO;  else if (wd_expire) state_n = S_ERR;
      S_LW_GO:  state_n = S_LW_WT;
      S_LW_WT:  if (ld_done) state_n = S_FC_GO;  else if (wd_expire) state_n = S_ERR;
      S_FC_GO:  state_n = S_FC_WT;
      S_FC_WT:  if (fc_done) state_n = S_SOF_GO; else if (wd_expire) state_n = S_ERR;
      S_SOF_GO: state_n = S_SOF_WT;
      S_SOF_WT: if (ld_done) state_n = S_DONE;   else if (wd_expire) state_n = S_ERR;
      S_DONE:   state_n = S_IDLE;
      S_ERR:    state_n = S_ERR;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      hold_off     <= 1'b0;
      lif_start    <= 1'b0;
      lw_start     <= 1'b0;
      fc_start     <= 1'b0;
      sof_start    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ld_base_addr <= '0;
      ld_cin       <= '0;
      ld_cout      <= '0;
      ld_has_bias  <= 1'b0;
      w_addr_q     <= '0;
      out_addr_q   <= '0;
      cycles       <= '0;
    end else begin
      state     <= state_n;
      hold_off  <= (state == S_DONE);
      lif_start <= (state_n == S_LIF_GO);
      lw_start  <= (state_n == S_LW_GO);
      fc_start  <= (state_n == S_FC_GO);
      sof_start <= (state_n == S_SOF_GO);
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);

      if (accept) begin
        ld_cin      <= cin;
        ld_cout     <= cout;
        ld_has_bias <= has_bias;
        w_addr_q    <= w_addr;
        out_addr_q  <= out_addr;
      end

      if (state_n == S_LIF_GO)      ld_base_addr <= in_addr;
      else if (state_n == S_LW_GO)  ld_base_addr <= w_addr_q;
      else if (state_n == S_SOF_GO) ld_base_addr <= out_addr_q;

      // The DONE cycle is already included by starting the count at 1.
      if (accept) begin
        cycles <= CYC_W'(1);
      end else if (state != S_IDLE && state != S_DONE && cycles != '1) begin
        cycles <= cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer; watchdog steps only with FC_SEQ_WDOG_EN.
module tb_fc_layer_sequencer;
  import fc_seq_pkg::*;

  localparam int AW = 27;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] cin, cout;
  logic          has_bias;
  logic [AW-1:0] in_addr, w_addr, out_addr;
  logic          lif_start, lw_start, sof_start, fc_start;
  logic [AW-1:0] ld_base_addr;
  logic [DW-1:0] ld_cin, ld_cout;
  logic          ld_has_bias;
  logic          ld_done, fc_done;
  logic          busy, done, error;
  logic [31:0]   cycles;

  int checks = 0;
  int errors = 0;
  int order[$];

  fc_layer_sequencer #(.ADDR_W(AW), .DIM_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cin(cin), .cout(cout),
    .has_bias(has_bias), .in_addr(in_addr), .w_addr(w_addr), .out_addr(out_addr),
    .lif_start(lif_start), .lw_start(lw_start), .sof_start(sof_start),
    .ld_base_addr(ld_base_addr), .ld_cin(ld_cin), .ld_cout(ld_cout),
    .ld_has_bias(ld_has_bias), .ld_done(ld_done), .fc_start(fc_start),
    .fc_done(fc_done), .busy(busy), .done(done), .cycles(cycles), .error(error)
  );

  always #5 clk = ~clk;

  // Pulse log: 1=lif 2=lw 3=fc 4=sof
  always @(posedge clk) begin
    if (!rst) begin
      if (lif_start) order.push_back(1);
      if (lw_start)  order.push_back(2);
      if (fc_start)  order.push_back(3);
      if (sof_start) order.push_back(4);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input int delay, input bit is_fc);
    repeat (delay) step();
    if (is_fc) fc_done = 1'b1;
    else       ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    fc_done = 1'b0;
  endtask

  function automatic int order_code();
    int c = 0;
    foreach (order[i]) c = c * 10 + order[i];
    return c;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; cin = '0; cout = '0; has_bias = 1'b0;
    in_addr = '0; w_addr = '0; out_addr = '0; ld_done = 1'b0; fc_done = 1'b0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_addr", ld_base_addr, 0);
    check("rst_cycles", cycles, 0);
    rst = 1'b0;
    step();
    order.delete();

    // Full layer: loader answers after 5 cycles, engine after 10, stray ld_done in FC_WT.
    cin = 12'd4; cout = 12'd3; has_bias = 1'b1;
    in_addr = 27'h0100; w_addr = 27'h2200; out_addr = 27'h3300;
    start = 1'b1;
    step();                              // cycle 1: LIF_GO
    start = 1'b0;
    cin = 12'd9; w_addr = 27'h7777; out_addr = 27'h6666;
    check("l1_lif_start", lif_start, 1);
    check("l1_busy", busy, 1);
    check("l1_addr_in", ld_base_addr, 27'h0100);
    check("l1_cin", ld_cin, 4);
    check("l1_cout", ld_cout, 3);
    check("l1_bias", ld_has_bias, 1);
    respond(5, 1'b0);                    // cycle 7: LW_GO
    check("l1_lw_start", lw_start, 1);
    check("l1_addr_w", ld_base_addr, 27'h2200);
    respond(5, 1'b0);                    // cycle 13: FC_GO
    check("l1_fc_start", fc_start, 1);
    repeat (3) step();                   // cycle 16
    ld_done = 1'b1;
    step();                              // cycle 17
    ld_done = 1'b0;
    check("l1_spurious_sof", sof_start, 0);
    check("l1_spurious_busy", busy, 1);
    check("l1_spurious_addr", ld_base_addr, 27'h2200);
    respond(6, 1'b1);                    // fc_done in cycle 23, cycle 24: SOF_GO
    check("l1_sof_start", sof_start, 1);
    check("l1_addr_out", ld_base_addr, 27'h3300);
    respond(5, 1'b0);                    // cycle 30: DONE
    check("l1_done", done, 1);
    check("l1_cycles", cycles, 30);
    step();                              // cycle 31: IDLE
    check("l1_done_once", done, 0);
    check("l1_idle_busy", busy, 0);
    check("l1_cycles_hold", cycles, 30);
    check("l1_addr_hold", ld_base_addr, 27'h3300);
    check("l1_order", order_code(), 1234);
    step();
    order.delete();

    // Zero input channels: straight to DONE, no loader/engine pulses.
    cin = 12'd0; cout = 12'd8; start = 1'b1;
    step();
    start = 1'b0;
    check("z_done", done, 1);
    check("z_cycles", cycles, 1);
    step();
    check("z_idle", busy, 0);
    check("z_no_pulses", order.size(), 0);
    step();

    // Reset in LW_WT, then a clean layer with 1-cycle responses.
    cin = 12'd2; cout = 12'd2; has_bias = 1'b0;
    in_addr = 27'h0011; w_addr = 27'h0022; out_addr = 27'h0033;
    start = 1'b1;
    step();
    start = 1'b0;
    respond(2, 1'b0);                    // LW_GO
    repeat (2) step();                   // LW_WT
    rst = 1'b1;
    #1;
    check("r_busy", busy, 0);
    check("r_addr", ld_base_addr, 0);
    check("r_cin", ld_cin, 0);
    check("r_cycles", cycles, 0);
    step();
    rst = 1'b0;
    step();
    check("r_no_pulse", lif_start, 0);
    check("r_still_idle", busy, 0);
    order.delete();
    in_addr = 27'h0044; w_addr = 27'h0055; out_addr = 27'h0066;
    start = 1'b1;
    step();
    start = 1'b0;
    check("r2_addr_in", ld_base_addr, 27'h0044);
    respond(1, 1'b0);
    respond(1, 1'b0);
    respond(1, 1'b1);
    check("r2_addr_out", ld_base_addr, 27'h0066);
    respond(1, 1'b0);                    // cycle 9: DONE
    check("r2_done", done, 1);
    check("r2_cycles", cycles, 9);
    check("r2_order", order_code(), 1234);
    step();
    step();

    // Start held through two layers.
    cin = 12'd1; cout = 12'd1; start = 1'b1;
    step();
    respond(1, 1'b0);
    respond(1, 1'b0);
    respond(1, 1'b1);
    respond(1, 1'b0);                    // first DONE
    check("h_done1", done, 1);
    check("h_cycles1", cycles, 9);
    step();
    check("h_gap1_lif", lif_start, 0);
    step();
    check("h_gap2_busy", busy, 0);
    step();
    check("h_lif2", lif_start, 1);
    check("h_cycles_clr", cycles, 1);
    start = 1'b0;
    respond(2, 1'b0);
    respond(2, 1'b0);
    respond(2, 1'b1);
    respond(2, 1'b0);
    check("h_done2", done, 1);
    check("h_cycles2", cycles, 13);
    step();
    step();

`ifdef FC_SEQ_WDOG_EN
    // Withhold ld_done after lw_start: ERR 16 cycles after LW_GO.
    start = 1'b1;
    step();
    start = 1'b0;
    respond(1, 1'b0);                    // LW_GO
    check("w_lw_start", lw_start, 1);
    repeat (15) step();
    check("w_pre_error", error, 0);
    step();
    check("w_error", error, 1);
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    repeat (3) step();
    check("w_error_sticky", error, 1);
    check("w_busy_sticky", busy, 1);
    check("w_no_done", done, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("w_error_clr", error, 0);
`else
    check("nowd_error", error, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
